seg7_scan_ctrl: RTL and testbench

Parametrised multiplexed seven-segment display controller and the successor to the fixed 8-digit hex scanner. It drives N_DIGITS common-anode digits from one clock. It adds per-digit decimal points, optional leading-zero blanking and PWM brightness. Input data is double-buffered and committed only at frame boundaries, so the display never tears. It sits between the CPU debug/IO registers and the board anode/segment pins.

---
 rtl/seg7_pkg.sv | 17 +
 rtl/hex_to_seg7.sv | 11 +
 rtl/seg7_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scanner: blank pattern, hex glyph
// table (active-low {g,f,e,d,c,b,a}) and the active-low anode selector.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] GLYPHS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E
    };

    // Up to 16 digits; callers truncate to their own digit count.
    function automatic logic [15:0] slot_onehot_n(input logic [3:0] idx);
        return ~(16'h0001 << idx);
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = GLYPHS[nibble_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode display scanner with frame-synchronous double
// buffering, per-digit decimal points, leading-zero blanking and PWM dimming.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int CLK_DIV  = 200000,
    parameter int BRIGHT_W = 4
) (
    input  logic                  clk_100M,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] data,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  lz_blank,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic [N_DIGITS-1:0]   an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done
);

    localparam int PRESC_W = $clog2(CLK_DIV);
    localparam int SLOT_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [BRIGHT_W-1:0]   pwm_q;

    logic [4*N_DIGITS-1:0] sh_data_q, act_data_q;
    logic [N_DIGITS-1:0]   sh_en_q, act_en_q;
    logic [N_DIGITS-1:0]   sh_dp_q, act_dp_q;

    logic [N_DIGITS-1:0]   an_q;
    logic [6:0]            seg_q;
    logic                  dp_q;
    logic                  frame_done_q;

    logic                  presc_wrap, commit;
    logic                  all_zero;
    logic [N_DIGITS-1:0]   lz_mask;
    logic [3:0]            cur_nib;
    logic                  cur_en, cur_dp, cur_lz;
    logic [6:0]            cur_glyph;
    logic [N_DIGITS-1:0]   an_sel;
    logic                  lit;

    assign presc_wrap = (presc_q == PRESC_W'(CLK_DIV - 1));
    assign commit     = presc_wrap && (slot_q == SLOT_W'(N_DIGITS - 1));

    always_comb begin
        presc_d = presc_wrap ? '0 : presc_q + 1'b1;
        slot_d  = slot_q;
        if (presc_wrap) begin
            slot_d = (slot_q == SLOT_W'(N_DIGITS - 1)) ? '0 : slot_q + 1'b1;
        end
    end

    // A digit is blanked while it and everything above it are zero; digit 0 always shows.
    always_comb begin
        all_zero = 1'b1;
        lz_mask  = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero & (act_data_q[4*i +: 4] == 4'h0);
            if (i != 0) begin
                lz_mask[i] = lz_blank & all_zero;
            end
        end
    end

    always_comb begin
        cur_nib = '0;
        cur_en  = 1'b0;
        cur_dp  = 1'b0;
        cur_lz  = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (slot_q == SLOT_W'(i)) begin
                cur_nib = act_data_q[4*i +: 4];
                cur_en  = act_en_q[i];
                cur_dp  = act_dp_q[i];
                cur_lz  = lz_mask[i];
            end
        end
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble_i (cur_nib),
        .seg_o    (cur_glyph)
    );

    assign an_sel = N_DIGITS'(slot_onehot_n(4'(slot_q)));
    // The first prescaler count of every slot is the break-before-make guard.
    assign lit    = cur_en && !cur_lz && (pwm_q <= bright) && (presc_q != '0);

    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            slot_q       <= '0;
            pwm_q        <= '0;
            sh_data_q    <= '0;
            sh_en_q      <= '0;
            sh_dp_q      <= '0;
            act_data_q   <= '0;
            act_en_q     <= '0;
            act_dp_q     <= '0;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            slot_q  <= slot_d;
            pwm_q   <= pwm_q + 1'b1;
            if (load) begin
                sh_data_q <= data;
                sh_en_q   <= digit_en;
                sh_dp_q   <= dp_in;
            end
            // Commit reads the shadow value from before this edge, so a coincident load waits a frame.
            if (commit) begin
                act_data_q <= sh_data_q;
                act_en_q   <= sh_en_q;
                act_dp_q   <= sh_dp_q;
            end
            an_q         <= lit ? an_sel : '1;
            seg_q        <= lit ? cur_glyph : SEG_BLANK;
            dp_q         <= lit ? ~cur_dp : 1'b1;
            frame_done_q <= commit;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl with 4 digits and 4 cycles per slot:
// the driver queues per-slot pin patterns, the monitor checks each frame.
module tb_seg7_scan_ctrl;

    localparam int N  = 4;
    localparam int CD = 4;
    localparam int BW = 4;
    localparam logic [11:0] BL = {4'hF, 7'h7F, 1'b1};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [15:0]   data = '0;
    logic [3:0]    digit_en = '0;
    logic [3:0]    dp_in = '0;
    logic          lz_blank = 1'b0;
    logic [BW-1:0] bright = '1;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp;
    logic          frame_done;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];

    seg7_scan_ctrl #(.N_DIGITS(N), .CLK_DIV(CD), .BRIGHT_W(BW)) dut (
        .clk_100M   (clk),
        .rst        (rst),
        .load       (load),
        .data       (data),
        .digit_en   (digit_en),
        .dp_in      (dp_in),
        .lz_blank   (lz_blank),
        .bright     (bright),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    // clock/reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    function automatic logic [11:0] it(input logic [3:0] a, input logic [6:0] s, input logic d);
        return {a, s, d};
    endfunction

    // driver tasks
    task automatic wait_fd();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 40);
        check("frame_done_arrives", {31'b0, frame_done}, 32'd1);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] en, input logic [3:0] p);
        data     = d;
        digit_en = en;
        dp_in    = p;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic push4(input logic [11:0] s0, input logic [11:0] s1,
                         input logic [11:0] s2, input logic [11:0] s3);
        exp_q.push_back(s0);
        exp_q.push_back(s1);
        exp_q.push_back(s2);
        exp_q.push_back(s3);
    endtask

    task automatic check_blank_pins(input string name);
        check(name, {20'b0, an, seg, dp}, {20'b0, BL});
    endtask

    // scoreboard monitor: a frame is armed at frame_done when four slot patterns are queued
    initial begin
        logic [11:0] cur;
        int pos, cyc, last_fd;
        logic armed;
        armed = 1'b0; pos = 0; cyc = 0; last_fd = -1; cur = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                armed = 1'b0; pos = 0; cyc = 0; last_fd = -1;
            end else begin
                cyc++;
                if (armed) begin
                    checks++;
                    if (pos % 4 == 0) begin
                        cur = exp_q.pop_front();
                        if ({an, seg, dp} !== BL) begin
                            errors++;
                            $display("FAIL guard slot%0d: got an=%h seg=%h dp=%b expected blank",
                                     pos / 4, an, seg, dp);
                        end
                    end else if ({an, seg, dp} !== cur) begin
                        errors++;
                        $display("FAIL slot%0d cyc%0d: got an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                                 pos / 4, pos % 4, an, seg, dp, cur[11:8], cur[7:1], cur[0]);
                    end
                    pos++;
                    if (pos == 16) armed = 1'b0;
                end
                if (frame_done) begin
                    if (last_fd >= 0) check("frame_period", cyc - last_fd, N * CD);
                    last_fd = cyc;
                    if (exp_q.size() >= 4) begin
                        armed = 1'b1;
                        pos = 0;
                    end
                end
            end
        end
    end

    // stimulus
    initial begin
        repeat (3) @(negedge clk);
        check_blank_pins("reset_pins");
        check("reset_frame_done", {31'b0, frame_done}, 32'd0);
        rst = 1'b0;
        repeat (3) push4(BL, BL, BL, BL);
        repeat (3) begin
            @(negedge clk);
            check_blank_pins("post_reset_pins");
        end
        repeat (4) wait_fd();

        // scan/decode: 1A3F, dp on digit 2
        do_load(16'h1A3F, 4'hF, 4'b0100);
        push4(it(4'hE, 7'h0E, 1), it(4'hD, 7'h30, 1), it(4'hB, 7'h08, 0), it(4'h7, 7'h79, 1));
        wait_fd(); wait_fd();

        // PWM: with a 16-cycle frame, pwm equals the frame position
        bright = 4'h3;
        push4(it(4'hE, 7'h0E, 1), BL, BL, BL);
        wait_fd(); wait_fd();
        bright = 4'h7;
        push4(it(4'hE, 7'h0E, 1), it(4'hD, 7'h30, 1), BL, BL);
        wait_fd(); wait_fd();
        bright = 4'hF;

        // tear-free: mid-frame load only shows after the next commit
        do_load(16'h1111, 4'hF, 4'b0000);
        push4(it(4'hE, 7'h79, 1), it(4'hD, 7'h79, 1), it(4'hB, 7'h79, 1), it(4'h7, 7'h79, 1));
        wait_fd();
        repeat (6) @(negedge clk);
        do_load(16'h2222, 4'hF, 4'b0000);
        push4(it(4'hE, 7'h24, 1), it(4'hD, 7'h24, 1), it(4'hB, 7'h24, 1), it(4'h7, 7'h24, 1));
        wait_fd(); wait_fd();

        // same-cycle load and commit
        repeat (15) @(negedge clk);
        push4(it(4'hE, 7'h24, 1), it(4'hD, 7'h24, 1), it(4'hB, 7'h24, 1), it(4'h7, 7'h24, 1));
        push4(it(4'hE, 7'h12, 0), it(4'hD, 7'h12, 1), it(4'hB, 7'h12, 1), it(4'h7, 7'h12, 0));
        do_load(16'h5555, 4'hF, 4'b1001);
        check("wrap_edge_aligned", {31'b0, frame_done}, 32'd1);
        wait_fd(); wait_fd();

        // digit enables
        do_load(16'h8421, 4'b1010, 4'b0000);
        push4(BL, it(4'hD, 7'h24, 1), BL, it(4'h7, 7'h00, 1));
        wait_fd(); wait_fd();

        // zeros without blanking
        do_load(16'h0040, 4'hF, 4'b0000);
        push4(it(4'hE, 7'h40, 1), it(4'hD, 7'h19, 1), it(4'hB, 7'h40, 1), it(4'h7, 7'h40, 1));
        wait_fd(); wait_fd();

        // leading-zero blanking, dp on a blanked digit does not keep it lit
        lz_blank = 1'b1;
        do_load(16'h0040, 4'hF, 4'b1000);
        push4(it(4'hE, 7'h40, 1), it(4'hD, 7'h19, 1), BL, BL);
        wait_fd(); wait_fd();
        do_load(16'h0000, 4'hF, 4'b0000);
        push4(it(4'hE, 7'h40, 1), BL, BL, BL);
        wait_fd(); wait_fd();

        // asynchronous mid-slot reset
        repeat (2) @(negedge clk);
        check("pre_reset_an", {28'b0, an}, 32'hE);
        rst = 1'b1;
        #1;
        check_blank_pins("async_reset_pins");
        check("async_reset_frame_done", {31'b0, frame_done}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push4(BL, BL, BL, BL);
        @(negedge clk);
        check_blank_pins("restart_pins");
        wait_fd(); wait_fd();

        check("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
